// File: rtl/usb_pkg.sv
// usb_pkg: shared USB definitions for the transmit path.
//   usb_tx_state_e        - NRZI transmitter state encoding
//   LINE_J/LINE_K/LINE_SE0 - line levels packed as {dp, dm}
//   USB_CLKS_PER_BIT_DFLT - default clk cycles per full-speed bit time
//   nrzi_next()           - next line level for one NRZI-encoded bit
package usb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA    = 2'd1,
    EOP_SE0 = 2'd2,
    EOP_J   = 2'd3
  } usb_tx_state_e;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam int USB_CLKS_PER_BIT_DFLT = 4;

  // A 0 toggles J<->K, a 1 holds the level. J and K are bitwise
  // complements, so inversion is the toggle.
  function automatic logic [1:0] nrzi_next(input logic [1:0] level, input logic b);
    return b ? level : ~level;
  endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// usb_bit_timer: bit-time counter and strobe for the USB NRZI transmitter.
// Ports:
//   clk    - system clock
//   nRST   - asynchronous active-low reset
//   clear  - synchronous clear of the counter to 0 (has priority)
//   enable - count 0..CLKS_PER_BIT-1 and wrap
//   strobe - high while enabled and the counter is at CLKS_PER_BIT-1
module usb_bit_timer
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = USB_CLKS_PER_BIT_DFLT
) (
  input  logic clk,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic strobe
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign strobe = enable & (cnt == CNT_MAX);

endmodule

// File: rtl/usb_nrzi_tx.sv
// usb_nrzi_tx: USB full-speed NRZI line encoder with EOP generation.
// Accepts stuffed bits over a valid/ready handshake, drives dp/dm with
// NRZI encoding (each level held CLKS_PER_BIT clks), then appends
// SE0 for two bit times and J for one bit time after the last bit.
// Ports:
//   clk, nRST          - clock, asynchronous active-low reset
//   in_bit, in_valid   - stuffed bit and its valid qualifier
//   in_last            - marks the final bit of the packet
//   in_ready           - bit accepted when in_valid & in_ready
//   dp, dm             - USB line levels
//   oe                 - transceiver output enable
//   busy               - high whenever not IDLE
//   underrun           - one-cycle pulse when the source starves a bit
//                        slot; present only with USB_NRZI_UNDERRUN_CHK_EN
// Build option: `define USB_NRZI_UNDERRUN_CHK_EN to abort a starved packet
// with an EOP; otherwise a starved slot repeats the level (a 1 bit).
//
// state   | meaning
// IDLE    | line J, oe low, waiting for first bit of a packet
// DATA    | sending NRZI bits, one per bit time
// EOP_SE0 | SE0 for two bit times
// EOP_J   | J for one bit time, then back to IDLE
module usb_nrzi_tx
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = USB_CLKS_PER_BIT_DFLT
) (
  input  logic clk,
  input  logic nRST,
  input  logic in_bit,
  input  logic in_valid,
  input  logic in_last,
  output logic in_ready,
  output logic dp,
  output logic dm,
  output logic oe,
  output logic busy
`ifdef USB_NRZI_UNDERRUN_CHK_EN
  ,
  output logic underrun
`endif
);

  usb_tx_state_e state;
  logic [1:0]    line;
  logic          last_pend;
  logic          eop_half;
  logic          strobe;
  logic          xfer;

  assign busy = (state != IDLE);
  assign oe   = busy;
  assign dp   = line[1];
  assign dm   = line[0];

  // Once the last bit is in flight, the next strobe only closes the
  // packet, so no further bit may be accepted there.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      DATA:    in_ready = strobe & ~last_pend;
      default: in_ready = 1'b0;
    endcase
  end

  assign xfer = in_valid & in_ready;

  // The timer is held at 0 in IDLE and free-runs across DATA and both EOP
  // states, so bit boundaries stay aligned with no bubble.
  usb_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .nRST   (nRST),
    .clear  (~busy),
    .enable (busy),
    .strobe (strobe)
  );

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      line      <= LINE_J;
      last_pend <= 1'b0;
      eop_half  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            state     <= DATA;
            line      <= nrzi_next(LINE_J, in_bit);
            last_pend <= in_last;
          end
        end
        DATA: begin
          if (strobe) begin
            if (last_pend) begin
              state     <= EOP_SE0;
              line      <= LINE_SE0;
              last_pend <= 1'b0;
              eop_half  <= 1'b0;
            end else if (xfer) begin
              line      <= nrzi_next(line, in_bit);
              last_pend <= in_last;
            end
`ifdef USB_NRZI_UNDERRUN_CHK_EN
            else begin
              state    <= EOP_SE0;
              line     <= LINE_SE0;
              eop_half <= 1'b0;
            end
`endif
          end
        end
        EOP_SE0: begin
          if (strobe) begin
            if (eop_half) begin
              state <= EOP_J;
              line  <= LINE_J;
            end else begin
              eop_half <= 1'b1;
            end
          end
        end
        EOP_J: begin
          if (strobe) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef USB_NRZI_UNDERRUN_CHK_EN
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      underrun <= 1'b0;
    end else begin
      underrun <= (state == DATA) & strobe & ~last_pend & ~in_valid;
    end
  end
`endif

endmodule

// File: tb/tb_usb_nrzi_tx.sv
// tb_usb_nrzi_tx: self-checking bench for usb_nrzi_tx (CLKS_PER_BIT=4).
// Each packet is turned into an expected per-cycle line/handshake
// timeline from the NRZI and EOP rules, then driven and compared cycle
// by cycle on the falling edge.
module tb_usb_nrzi_tx;

  localparam int C = 4;
  localparam logic [1:0] J = 2'b10;
  localparam logic [1:0] SE0 = 2'b00;

  logic clk = 1'b0;
  logic nRST;
  logic in_bit, in_valid, in_last;
  logic in_ready, dp, dm, oe, busy;
`ifdef USB_NRZI_UNDERRUN_CHK_EN
  logic underrun;
`endif

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  usb_nrzi_tx #(.CLKS_PER_BIT(C)) dut (
    .clk      (clk),
    .nRST     (nRST),
    .in_bit   (in_bit),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .dp       (dp),
    .dm       (dm),
    .oe       (oe),
    .busy     (busy)
`ifdef USB_NRZI_UNDERRUN_CHK_EN
    ,
    .underrun (underrun)
`endif
  );

  int         pkt_bits[$];
  logic [1:0] e_line[$];
  logic       e_oe[$];
  logic       e_rdy[$];
  logic       e_und[$];
  logic       d_valid[$];
  logic       d_bit[$];
  logic       d_last[$];

  task automatic check(input string tag, input int t, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
    end
  endtask

  task automatic add(input logic [1:0] l, input logic o, input logic r, input logic u,
                     input logic v, input logic b, input logic la);
    e_line.push_back(l);
    e_oe.push_back(o);
    e_rdy.push_back(r);
    e_und.push_back(u);
    d_valid.push_back(v);
    d_bit.push_back(b);
    d_last.push_back(la);
  endtask

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic check_all(input int t, input logic [1:0] l, input logic o, input logic r,
                           input logic u);
    check("dp", t, dp, l[1]);
    check("dm", t, dm, l[0]);
    check("oe", t, oe, o);
    check("busy", t, busy, o);
    check("in_ready", t, in_ready, r);
`ifdef USB_NRZI_UNDERRUN_CHK_EN
    check("underrun", t, underrun, u);
`else
    if (u !== 1'b0) check("underrun_model", t, 1'b1, 1'b0);
`endif
  endtask

  // stall_at: index of the bit before which the source starves one slot
  // (-1: none). abort_at: timeline cycle at which nRST is pulsed (-1: none).
  task automatic run_packet(input int stall_at, input int abort_at);
    int         slots[$];
    bit         aborted;
    logic [1:0] level;
    int         n;
    aborted = 1'b0;
    level   = J;
    e_line.delete(); e_oe.delete(); e_rdy.delete(); e_und.delete();
    d_valid.delete(); d_bit.delete(); d_last.delete();

    for (int i = 0; i < pkt_bits.size(); i++) begin
      if (i == stall_at) begin
`ifdef USB_NRZI_UNDERRUN_CHK_EN
        aborted = 1'b1;
        break;
`else
        slots.push_back(2);
`endif
      end
      slots.push_back(pkt_bits[i]);
    end
    n = slots.size();

    add(J, 1'b0, 1'b1, 1'b0, 1'b1, logic'(slots[0] == 1), logic'(n == 1 && !aborted));
    for (int j = 0; j < n; j++) begin
      if (slots[j] == 0) level = ~level;
      for (int c = 0; c < C; c++) begin
        if (c == C - 1 && j < n - 1) begin
          if (slots[j + 1] == 2)
            add(level, 1'b1, 1'b1, 1'b0, 1'b0, rnd(), rnd());
          else
            add(level, 1'b1, 1'b1, 1'b0, 1'b1, logic'(slots[j + 1] == 1),
                logic'(j + 1 == n - 1 && !aborted));
        end else if (c == C - 1 && aborted) begin
          add(level, 1'b1, 1'b1, 1'b0, 1'b0, rnd(), rnd());
        end else begin
          add(level, 1'b1, 1'b0, 1'b0, rnd(), rnd(), rnd());
        end
      end
    end
    for (int k = 0; k < 2 * C; k++)
      add(SE0, 1'b1, 1'b0, logic'(k == 0 && aborted), rnd(), rnd(), rnd());
    for (int k = 0; k < C; k++)
      add(J, 1'b1, 1'b0, 1'b0, rnd(), rnd(), rnd());
    add(J, 1'b0, 1'b1, 1'b0, 1'b0, rnd(), rnd());

    for (int t = 0; t < e_line.size(); t++) begin
      @(negedge clk);
      if (t == abort_at) begin
        nRST = 1'b0;
        #1;
        check_all(t, J, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nRST = 1'b1;
        return;
      end
      check_all(t, e_line[t], e_oe[t], e_rdy[t], e_und[t]);
      in_valid = d_valid[t];
      in_bit   = d_bit[t];
      in_last  = d_last[t];
    end
  endtask

  initial begin
    int n, stall;
    nRST     = 1'b0;
    in_bit   = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (3) @(negedge clk);
    check_all(-1, J, 1'b0, 1'b1, 1'b0);
    nRST = 1'b1;

    // SYNC, then a run of six ones, then a final 0 closing with EOP
    pkt_bits = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
    run_packet(-1, -1);

    // source starves the slot before bit index 2
    pkt_bits = '{0, 1, 0, 0, 1};
    run_packet(2, -1);

    // reset asserted during EOP_SE0, then a single-bit packet starting from J
    pkt_bits = '{1, 0};
    run_packet(-1, 1 + 2 * C + 3);
    pkt_bits = '{0};
    run_packet(-1, -1);

    for (int p = 0; p < 8; p++) begin
      n = $urandom_range(1, 12);
      pkt_bits.delete();
      for (int i = 0; i < n; i++) pkt_bits.push_back($urandom_range(0, 1));
      stall = (n >= 2 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : -1;
      run_packet(stall, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
